// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns one EX/MEM request into one word-aligned bus
// transaction, stalls until ack or timeout, then returns a one-cycle formatted response.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [1:0] size_q;
    logic [1:0] lane_q;
    logic       uns_q;
    logic       write_q;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] format_load(input logic [1:0]  size,
                                                input logic        uns,
                                                input logic [1:0]  lane,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return rdata;
        endcase
    endfunction

    // Gated by reset so the pipeline is never held while the unit is in reset.
    assign stall = rst & (((state == IDLE) & req_valid) | (state == BUSY));

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            size_q  <= req_size;
            lane_q  <= req_addr[1:0];
            uns_q   <= req_unsigned;
            write_q <= req_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            resp_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            load_data  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            misaligned <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= req_write;
                            dmem_addr  <= {req_addr[31:2], 2'b00};
                            dmem_be    <= byte_enables(req_size, req_addr[1:0]);
                            dmem_wdata <= store_data(req_size, req_wdata);
                            wait_cnt   <= '0;
                            state      <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // An ack arriving in the final wait cycle still completes normally.
                    if (dmem_ack || wait_cnt == LAST_WAIT) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_be    <= '0;
                        dmem_wdata <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                        if (dmem_ack) begin
                            load_data <= write_q ? 32'h0
                                                 : format_load(size_q, uns_q, lane_q, dmem_rdata);
                        end else begin
                            bus_error <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    misaligned <= 1'b0;
                    bus_error  <= 1'b0;
                    load_data  <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan scenarios plus randomized accesses
// checked against an arithmetic reference model of the load/store rules.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;

    int checks = 0;
    int errors = 0;

    int          o_req_first, o_req_cnt, o_stall_cnt, o_stall_last, o_resp_cyc;
    logic        o_stable, o_we, o_mis, o_err, o_post_valid;
    logic [31:0] o_addr, o_wdata, o_load, o_post_load;
    logic [3:0]  o_be;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .resp_valid(resp_valid), .load_data(load_data),
        .misaligned(misaligned), .bus_error(bus_error), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata)
    );

    // Reference model: access width in bytes drives every rule.
    function automatic bit m_misal(input logic [1:0] sz, input logic [31:0] a);
        int unsigned nb;
        if (sz == 2'd3) return 1'b1;
        nb = 1 << sz;
        return (a % nb) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned nb, v;
        nb = 1 << sz;
        v = ((1 << nb) - 1) << (a % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic un,
                                           input logic [31:0] a, input logic [31:0] rd);
        int unsigned nb;
        logic [31:0] mask, val;
        if (sz == 2'd2) return rd;
        nb   = 1 << sz;
        mask = (32'h1 << (8 * nb)) - 32'h1;
        val  = (rd >> (8 * (a % 4))) & mask;
        if (!un && val[8*nb-1]) val = val | ~mask;
        return val;
    endfunction

    // Drives one request at cycle 0 and records what the DUT does, cycle by cycle.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic un,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_cyc);
        o_req_first = -1; o_req_cnt = 0; o_stall_cnt = 0; o_stall_last = -1; o_resp_cyc = -1;
        o_stable = 1'b1; o_we = 1'b0; o_addr = '0; o_be = '0; o_wdata = '0;
        o_load = 32'hDEAD_DEAD; o_mis = 1'bx; o_err = 1'bx;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd; dmem_rdata = rd;
        for (int c = 0; c < 40 && o_resp_cyc < 0; c++) begin
            dmem_ack = (ack_cyc > 0 && c == ack_cyc);
            @(negedge clk);
            if (stall) begin o_stall_cnt++; o_stall_last = c; end
            if (dmem_req) begin
                o_req_cnt++;
                if (o_req_first < 0) begin
                    o_req_first = c; o_we = dmem_we; o_addr = dmem_addr;
                    o_be = dmem_be; o_wdata = dmem_wdata;
                end else if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {o_we, o_addr, o_be, o_wdata}) begin
                    o_stable = 1'b0;
                end
            end
            if (resp_valid) begin
                o_resp_cyc = c; o_load = load_data; o_mis = misaligned; o_err = bus_error;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
        o_post_valid = resp_valid; o_post_load = load_data;
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = '0; dmem_rdata = '0; dmem_ack = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({stall, resp_valid, misaligned, bus_error} !== 4'b0) begin errors++;
            $display("FAIL reset_ctrl got %b exp 0000", {stall, resp_valid, misaligned, bus_error}); end
        checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data} !== '0) begin errors++;
            $display("FAIL reset_bus req=%b we=%b be=%h addr=%h wd=%h ld=%h exp all 0",
                     dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, load_data); end
        req_valid = 1'b0; dmem_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({stall, dmem_req, resp_valid} !== 3'b0) begin errors++;
            $display("FAIL reset_release_idle got %b exp 000", {stall, dmem_req, resp_valid}); end
    endtask

    task automatic test_lb_signed;
        run_access(1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        checks++; if (o_addr !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr got %h exp 00001000", o_addr); end
        checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b exp 1000", o_be); end
        checks++; if (o_req_first !== 1 || o_req_cnt !== 1) begin errors++;
            $display("FAIL lb_req first=%0d cnt=%0d exp 1/1", o_req_first, o_req_cnt); end
        checks++; if (o_resp_cyc !== 2) begin errors++; $display("FAIL lb_resp_cyc got %0d exp 2", o_resp_cyc); end
        checks++; if (o_load !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", o_load); end
        checks++; if (o_post_valid !== 1'b0 || o_post_load !== 32'h0) begin errors++;
            $display("FAIL lb_one_cycle valid=%b data=%h exp 0/0", o_post_valid, o_post_load); end
    endtask

    task automatic test_lhu_wait;
        run_access(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 4);
        checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL lhu_be got %b exp 1100", o_be); end
        checks++; if (o_load !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got %h exp 0000beef", o_load); end
        checks++; if (o_stall_cnt !== 5 || o_stall_last !== 4) begin errors++;
            $display("FAIL lhu_stall cnt=%0d last=%0d exp 5/4", o_stall_cnt, o_stall_last); end
        checks++; if (o_resp_cyc !== 5 || o_err !== 1'b0) begin errors++;
            $display("FAIL lhu_resp cyc=%0d err=%b exp 5/0", o_resp_cyc, o_err); end
        checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL lhu_bus_stable got %b exp 1", o_stable); end
    endtask

    task automatic test_sb;
        run_access(1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h1234_56AB, 32'hFFFF_FFFF, 2);
        checks++; if (o_we !== 1'b1 || o_be !== 4'b0010) begin errors++;
            $display("FAIL sb_we_be we=%b be=%b exp 1/0010", o_we, o_be); end
        checks++; if (o_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h exp abababab", o_wdata); end
        checks++; if (o_load !== 32'h0 || o_resp_cyc !== 3) begin errors++;
            $display("FAIL sb_resp data=%h cyc=%0d exp 0/3", o_load, o_resp_cyc); end
    endtask

    task automatic test_misaligned;
        run_access(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 32'h1234_5678, 1);
        checks++; if (o_req_cnt !== 0) begin errors++; $display("FAIL mis_no_req got %0d req cycles exp 0", o_req_cnt); end
        checks++; if (o_resp_cyc !== 1 || o_mis !== 1'b1 || o_err !== 1'b0) begin errors++;
            $display("FAIL mis_resp cyc=%0d mis=%b err=%b exp 1/1/0", o_resp_cyc, o_mis, o_err); end
        checks++; if (o_stall_cnt !== 1 || o_stall_last !== 0) begin errors++;
            $display("FAIL mis_stall cnt=%0d last=%0d exp 1/0", o_stall_cnt, o_stall_last); end
        checks++; if (o_load !== 32'h0) begin errors++; $display("FAIL mis_data got %h exp 0", o_load); end
    endtask

    task automatic test_timeout;
        run_access(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h5555_AAAA, 0);
        checks++; if (o_req_first !== 1 || o_req_cnt !== TO) begin errors++;
            $display("FAIL to_req first=%0d cnt=%0d exp 1/%0d", o_req_first, o_req_cnt, TO); end
        checks++; if (o_resp_cyc !== TO + 1 || o_err !== 1'b1 || o_mis !== 1'b0) begin errors++;
            $display("FAIL to_resp cyc=%0d err=%b mis=%b exp %0d/1/0", o_resp_cyc, o_err, o_mis, TO + 1); end
        checks++; if (o_load !== 32'h0) begin errors++; $display("FAIL to_data got %h exp 0", o_load); end
        run_access(1'b0, 2'd2, 1'b0, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, TO);
        checks++; if (o_resp_cyc !== TO + 1 || o_err !== 1'b0) begin errors++;
            $display("FAIL ack_at_to cyc=%0d err=%b exp %0d/0", o_resp_cyc, o_err, TO + 1); end
        checks++; if (o_load !== 32'hCAFE_F00D) begin errors++; $display("FAIL ack_at_to_data got %h exp cafef00d", o_load); end
    endtask

    task automatic test_ack_outside_busy;
        int bad;
        bad = 0;
        @(posedge clk); #1;
        dmem_ack = 1'b1; req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || dmem_req || stall) bad++;
        end
        dmem_ack = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL idle_ack got %0d active cycles exp 0", bad); end
    endtask

    task automatic test_reset_busy;
        int bad;
        bad = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_6000; dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_busy dmem_req got %b exp 1", dmem_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({dmem_req, stall, resp_valid} !== 3'b0) begin errors++;
            $display("FAIL rb_async req/stall/resp got %b exp 000", {dmem_req, stall, resp_valid}); end
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid || dmem_req) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL rb_no_resp got %0d active cycles exp 0", bad); end
        run_access(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0, 32'h1122_3344, 2);
        checks++; if (o_resp_cyc !== 3 || o_load !== 32'h1122_3344 || o_err !== 1'b0) begin errors++;
            $display("FAIL rb_after cyc=%0d data=%h err=%b exp 3/11223344/0", o_resp_cyc, o_load, o_err); end
    endtask

    task automatic test_random;
        logic        wr, un;
        logic [1:0]  sz;
        logic [31:0] a, wd, rd, e_load;
        int          ack, e_req, e_resp;
        bit          e_mis, e_err;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom); un = 1'($urandom); sz = 2'($urandom);
            a = $urandom; wd = $urandom; rd = $urandom;
            if (($urandom % 4) != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
            ack = $urandom_range(0, TO + 1);
            run_access(wr, sz, un, a, wd, rd, ack);
            e_mis = m_misal(sz, a);
            e_err = 1'b0; e_load = 32'h0;
            if (e_mis) begin
                e_req = 0; e_resp = 1;
            end else if (ack >= 1 && ack <= TO) begin
                e_req = ack; e_resp = ack + 1;
                if (!wr) e_load = m_load(sz, un, a, rd);
            end else begin
                e_req = TO; e_resp = TO + 1; e_err = 1'b1;
            end
            checks++; if (o_resp_cyc !== e_resp || o_req_cnt !== e_req) begin errors++;
                $display("FAIL rnd%0d_timing resp=%0d req=%0d exp %0d/%0d", i, o_resp_cyc, o_req_cnt, e_resp, e_req); end
            checks++; if (o_stall_cnt !== e_resp || o_stall_last !== e_resp - 1) begin errors++;
                $display("FAIL rnd%0d_stall cnt=%0d last=%0d exp %0d/%0d", i, o_stall_cnt, o_stall_last, e_resp, e_resp - 1); end
            checks++; if (o_load !== e_load || o_mis !== e_mis || o_err !== e_err) begin errors++;
                $display("FAIL rnd%0d_resp data=%h mis=%b err=%b exp %h/%b/%b", i, o_load, o_mis, o_err, e_load, e_mis, e_err); end
            checks++; if (o_post_valid !== 1'b0 || o_post_load !== 32'h0) begin errors++;
                $display("FAIL rnd%0d_pulse valid=%b data=%h exp 0/0", i, o_post_valid, o_post_load); end
            if (!e_mis) begin
                checks++; if (o_req_first !== 1 || o_we !== wr || o_addr !== (a & ~32'h3) || o_be !== m_be(sz, a) || o_stable !== 1'b1) begin errors++;
                    $display("FAIL rnd%0d_bus first=%0d we=%b addr=%h be=%b stable=%b exp 1/%b/%h/%b/1",
                             i, o_req_first, o_we, o_addr, o_be, o_stable, wr, a & ~32'h3, m_be(sz, a)); end
                if (wr) begin
                    checks++; if (o_wdata !== m_wdata(sz, wd)) begin errors++;
                        $display("FAIL rnd%0d_wdata got %h exp %h", i, o_wdata, m_wdata(sz, wd)); end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_lb_signed;
        test_lhu_wait;
        test_sb;
        test_misaligned;
        test_timeout;
        test_ack_outside_busy;
        test_reset_busy;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
